// File: rtl/tl_buffer_pkg.sv
// Shared TileLink-UL field widths and packed beat types for the periph-path buffer stage.
package tl_buffer_pkg;

    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 3;
    localparam int SIZE_W   = 4;
    localparam int SOURCE_W = 5;
    localparam int ADDR_W   = 31;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;

    typedef struct packed {
        logic                bufferable;
        logic                modifiable;
        logic                readalloc;
        logic                writealloc;
        logic                privileged;
        logic                secure;
        logic                fetch;
    } tl_amba_prot_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        tl_amba_prot_t       prot;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_a_bits_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic                denied;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } tl_d_bits_t;

endpackage

// File: rtl/tl_buffer_queue.sv
// Generic ready/valid circular FIFO carrying an opaque payload.
// Optional same-cycle bypass when empty is enabled by defining TL_BUFFER_FLOW_EN.
module tl_buffer_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_bits,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_bits
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] ram [DEPTH];
    logic [PTR_W-1:0] enq_ptr;
    logic [PTR_W-1:0] deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             full;
    logic             empty;
    logic             do_enq;
    logic             do_deq;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign ptr_match = (enq_ptr == deq_ptr);
    assign full      = ptr_match & maybe_full;
    assign empty     = ptr_match & ~maybe_full;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_ready  = ~full;
        out_valid = ~empty;
        out_bits  = ram[deq_ptr];
        do_enq    = in_valid & ~full;
        do_deq    = out_ready & ~empty;
`ifdef TL_BUFFER_FLOW_EN
        if (empty && in_valid) begin
            out_valid = 1'b1;
            out_bits  = in_bits;
            // A bypassed beat that is taken immediately never touches the RAM.
            if (out_ready) begin
                do_enq = 1'b0;
            end
        end
`endif
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= next_ptr(enq_ptr);
            end
            if (do_deq) begin
                deq_ptr <= next_ptr(deq_ptr);
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

    // NOTE: payload RAM is deliberately not reset; its contents are unobservable while empty.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            ram[enq_ptr] <= in_bits;
        end
    end

endmodule

// File: rtl/tl_buffer_ad.sv
// Registered TileLink-UL buffer on the A and D channels ahead of the 32-bit width widget.
// Define TL_BUFFER_FLOW_EN to let beats bypass an empty FIFO in the same cycle.
module tl_buffer_ad
    import tl_buffer_pkg::*;
#(
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    output logic                auto_in_a_ready,
    input  logic                auto_in_a_valid,
    input  logic [OPCODE_W-1:0] auto_in_a_bits_opcode,
    input  logic [PARAM_W-1:0]  auto_in_a_bits_param,
    input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic                auto_in_a_bits_user_amba_prot_bufferable,
    input  logic                auto_in_a_bits_user_amba_prot_modifiable,
    input  logic                auto_in_a_bits_user_amba_prot_readalloc,
    input  logic                auto_in_a_bits_user_amba_prot_writealloc,
    input  logic                auto_in_a_bits_user_amba_prot_privileged,
    input  logic                auto_in_a_bits_user_amba_prot_secure,
    input  logic                auto_in_a_bits_user_amba_prot_fetch,
    input  logic [MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_a_bits_data,
    input  logic                auto_in_a_bits_corrupt,
    input  logic                auto_out_a_ready,
    output logic                auto_out_a_valid,
    output logic [OPCODE_W-1:0] auto_out_a_bits_opcode,
    output logic [PARAM_W-1:0]  auto_out_a_bits_param,
    output logic [SIZE_W-1:0]   auto_out_a_bits_size,
    output logic [SOURCE_W-1:0] auto_out_a_bits_source,
    output logic [ADDR_W-1:0]   auto_out_a_bits_address,
    output logic                auto_out_a_bits_user_amba_prot_bufferable,
    output logic                auto_out_a_bits_user_amba_prot_modifiable,
    output logic                auto_out_a_bits_user_amba_prot_readalloc,
    output logic                auto_out_a_bits_user_amba_prot_writealloc,
    output logic                auto_out_a_bits_user_amba_prot_privileged,
    output logic                auto_out_a_bits_user_amba_prot_secure,
    output logic                auto_out_a_bits_user_amba_prot_fetch,
    output logic [MASK_W-1:0]   auto_out_a_bits_mask,
    output logic [DATA_W-1:0]   auto_out_a_bits_data,
    output logic                auto_out_a_bits_corrupt,
    input  logic                auto_in_d_ready,
    output logic                auto_in_d_valid,
    output logic [OPCODE_W-1:0] auto_in_d_bits_opcode,
    output logic [SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [SOURCE_W-1:0] auto_in_d_bits_source,
    output logic                auto_in_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_d_bits_data,
    output logic                auto_in_d_bits_corrupt,
    output logic                auto_out_d_ready,
    input  logic                auto_out_d_valid,
    input  logic [OPCODE_W-1:0] auto_out_d_bits_opcode,
    input  logic [SIZE_W-1:0]   auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0] auto_out_d_bits_source,
    input  logic                auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]   auto_out_d_bits_data,
    input  logic                auto_out_d_bits_corrupt
);

    tl_a_bits_t a_enq;
    tl_a_bits_t a_deq;
    tl_d_bits_t d_enq;
    tl_d_bits_t d_deq;

    assign a_enq.opcode          = auto_in_a_bits_opcode;
    assign a_enq.param           = auto_in_a_bits_param;
    assign a_enq.size            = auto_in_a_bits_size;
    assign a_enq.source          = auto_in_a_bits_source;
    assign a_enq.address         = auto_in_a_bits_address;
    assign a_enq.prot.bufferable = auto_in_a_bits_user_amba_prot_bufferable;
    assign a_enq.prot.modifiable = auto_in_a_bits_user_amba_prot_modifiable;
    assign a_enq.prot.readalloc  = auto_in_a_bits_user_amba_prot_readalloc;
    assign a_enq.prot.writealloc = auto_in_a_bits_user_amba_prot_writealloc;
    assign a_enq.prot.privileged = auto_in_a_bits_user_amba_prot_privileged;
    assign a_enq.prot.secure     = auto_in_a_bits_user_amba_prot_secure;
    assign a_enq.prot.fetch      = auto_in_a_bits_user_amba_prot_fetch;
    assign a_enq.mask            = auto_in_a_bits_mask;
    assign a_enq.data            = auto_in_a_bits_data;
    assign a_enq.corrupt         = auto_in_a_bits_corrupt;

    assign auto_out_a_bits_opcode                    = a_deq.opcode;
    assign auto_out_a_bits_param                     = a_deq.param;
    assign auto_out_a_bits_size                      = a_deq.size;
    assign auto_out_a_bits_source                    = a_deq.source;
    assign auto_out_a_bits_address                   = a_deq.address;
    assign auto_out_a_bits_user_amba_prot_bufferable = a_deq.prot.bufferable;
    assign auto_out_a_bits_user_amba_prot_modifiable = a_deq.prot.modifiable;
    assign auto_out_a_bits_user_amba_prot_readalloc  = a_deq.prot.readalloc;
    assign auto_out_a_bits_user_amba_prot_writealloc = a_deq.prot.writealloc;
    assign auto_out_a_bits_user_amba_prot_privileged = a_deq.prot.privileged;
    assign auto_out_a_bits_user_amba_prot_secure     = a_deq.prot.secure;
    assign auto_out_a_bits_user_amba_prot_fetch      = a_deq.prot.fetch;
    assign auto_out_a_bits_mask                      = a_deq.mask;
    assign auto_out_a_bits_data                      = a_deq.data;
    assign auto_out_a_bits_corrupt                   = a_deq.corrupt;

    assign d_enq.opcode  = auto_out_d_bits_opcode;
    assign d_enq.size    = auto_out_d_bits_size;
    assign d_enq.source  = auto_out_d_bits_source;
    assign d_enq.denied  = auto_out_d_bits_denied;
    assign d_enq.data    = auto_out_d_bits_data;
    assign d_enq.corrupt = auto_out_d_bits_corrupt;

    assign auto_in_d_bits_opcode  = d_deq.opcode;
    assign auto_in_d_bits_size    = d_deq.size;
    assign auto_in_d_bits_source  = d_deq.source;
    assign auto_in_d_bits_denied  = d_deq.denied;
    assign auto_in_d_bits_data    = d_deq.data;
    assign auto_in_d_bits_corrupt = d_deq.corrupt;

    tl_buffer_queue #(
        .DEPTH (A_DEPTH),
        .WIDTH ($bits(tl_a_bits_t))
    ) u_a_queue (
        .clock     (clock),
        .reset     (reset),
        .in_ready  (auto_in_a_ready),
        .in_valid  (auto_in_a_valid),
        .in_bits   (a_enq),
        .out_ready (auto_out_a_ready),
        .out_valid (auto_out_a_valid),
        .out_bits  (a_deq)
    );

    // D flows the other way: the widget side is the enqueue side.
    tl_buffer_queue #(
        .DEPTH (D_DEPTH),
        .WIDTH ($bits(tl_d_bits_t))
    ) u_d_queue (
        .clock     (clock),
        .reset     (reset),
        .in_ready  (auto_out_d_ready),
        .in_valid  (auto_out_d_valid),
        .in_bits   (d_enq),
        .out_ready (auto_in_d_ready),
        .out_valid (auto_in_d_valid),
        .out_bits  (d_deq)
    );

endmodule
